fpu_align_ctrl: RTL and testbench

FPU_ALIGN_CTRL -- requirements
Module: fpu_align_ctrl

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fpu_exp_compare.sv | 42 ++++
 rtl/fpu_align_ctrl.sv | 110 +++++++++++
 tb/tb_fpu_align_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the FP add/sub alignment path: exponent relation codes,
// shift clamp and the alignment controller state machine.
package fpu_pkg;

  localparam logic [1:0] AGREATER = 2'b10;
  localparam logic [1:0] BGREATER = 2'b00;
  localparam logic [1:0] EQUAL    = 2'b11;

  localparam int unsigned SHIFT_W     = 5;
  localparam int unsigned SHIFT_CLAMP = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } align_state_e;

endpackage

// File: rtl/fpu_exp_compare.sv
// Exponent comparator: relation code, clamped alignment distance, larger
// exponent and zero/inf-nan exponent detection.
module fpu_exp_compare
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH = 8
) (
  input  logic [EXP_WIDTH-1:0] exp_a,
  input  logic [EXP_WIDTH-1:0] exp_b,
  output logic [1:0]           disc,
  output logic [SHIFT_W-1:0]   shift,
  output logic [EXP_WIDTH-1:0] exp_max,
  output logic                 special
);

  // One extra bit so the difference never wraps before clamping.
  logic [EXP_WIDTH:0] ext_a, ext_b, diff;

  assign ext_a = {1'b0, exp_a};
  assign ext_b = {1'b0, exp_b};

  always_comb begin
    disc    = EQUAL;
    diff    = '0;
    exp_max = exp_a;
    if (ext_a > ext_b) begin
      disc    = AGREATER;
      diff    = ext_a - ext_b;
      exp_max = exp_a;
    end else if (ext_b > ext_a) begin
      disc    = BGREATER;
      diff    = ext_b - ext_a;
      exp_max = exp_b;
    end
  end

  assign shift = (diff > (EXP_WIDTH+1)'(SHIFT_CLAMP)) ? SHIFT_W'(SHIFT_CLAMP)
                                                    : diff[SHIFT_W-1:0];

  assign special = (exp_a == '0) || (&exp_a) || (exp_b == '0) || (&exp_b);

endmodule

// File: rtl/fpu_align_ctrl.sv
// Alignment controller: accepts an operand pair, drives the external
// one-cycle shifter, captures its aligned mantissas and hands them downstream.
module fpu_align_ctrl
  import fpu_pkg::*;
#(
  parameter int MANTISSA_WIDTH = 23,
  parameter int EXP_WIDTH      = 8
) (
  input  logic                                  clk,
  input  logic                                  srst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     op_a,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     op_b,
  input  logic                                  op_sub,
  output logic [MANTISSA_WIDTH-1:0]             ma,
  output logic [MANTISSA_WIDTH-1:0]             mb,
  output logic [4:0]                            shift_spaces,
  output logic [1:0]                            exp_disc,
  input  logic [MANTISSA_WIDTH+3:0]             mantissa_a_out,
  input  logic [MANTISSA_WIDTH+3:0]             mantissa_b_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [MANTISSA_WIDTH+3:0]             out_ma,
  output logic [MANTISSA_WIDTH+3:0]             out_mb,
  output logic [EXP_WIDTH-1:0]                  out_exp,
  output logic                                  out_sa,
  output logic                                  out_sb,
  output logic                                  out_eff_sub,
  output logic                                  out_special
);

  localparam int SIGN_BIT = EXP_WIDTH + MANTISSA_WIDTH;

  align_state_e               state;
  logic [EXP_WIDTH-1:0]       exp_a, exp_b, exp_max;
  logic [1:0]                 disc;
  logic [SHIFT_W-1:0]         shift;
  logic                       special;

  assign exp_a = op_a[SIGN_BIT-1 -: EXP_WIDTH];
  assign exp_b = op_b[SIGN_BIT-1 -: EXP_WIDTH];

  fpu_exp_compare #(
    .EXP_WIDTH (EXP_WIDTH)
  ) u_exp_cmp (
    .exp_a   (exp_a),
    .exp_b   (exp_b),
    .disc    (disc),
    .shift   (shift),
    .exp_max (exp_max),
    .special (special)
  );

  // Shifter-facing fields are only written on accept, so they stay stable
  // for the whole operation.
  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      ma           <= '0;
      mb           <= '0;
      shift_spaces <= '0;
      exp_disc     <= EQUAL;
      out_ma       <= '0;
      out_mb       <= '0;
      out_exp      <= '0;
      out_sa       <= 1'b0;
      out_sb       <= 1'b0;
      out_eff_sub  <= 1'b0;
      out_special  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ma           <= op_a[MANTISSA_WIDTH-1:0];
            mb           <= op_b[MANTISSA_WIDTH-1:0];
            shift_spaces <= shift;
            exp_disc     <= disc;
            out_exp      <= exp_max;
            out_sa       <= op_a[SIGN_BIT];
            out_sb       <= op_b[SIGN_BIT];
            out_eff_sub  <= op_a[SIGN_BIT] ^ op_b[SIGN_BIT] ^ op_sub;
            out_special  <= special;
            in_ready     <= 1'b0;
            state        <= SHIFT;
          end
        end
        // Shifter registers its inputs on this edge.
        SHIFT: state <= CAPT;
        CAPT: begin
          out_ma    <= mantissa_a_out;
          out_mb    <= mantissa_b_out;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_align_ctrl.sv
// Bench for fpu_align_ctrl: behavioural shifter, scoreboard queue of
// expected results, directed cases plus randomized operand pairs.
module tb_fpu_align_ctrl;

  localparam int MW = 23;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          srst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   op_a, op_b;
  logic          op_sub;
  logic [MW-1:0] ma, mb;
  logic [4:0]    shift_spaces;
  logic [1:0]    exp_disc;
  logic [MW+3:0] mantissa_a_out = '0;
  logic [MW+3:0] mantissa_b_out = '0;
  logic          out_valid;
  logic          out_ready;
  logic [MW+3:0] out_ma, out_mb;
  logic [EW-1:0] out_exp;
  logic          out_sa, out_sb, out_eff_sub, out_special;

  fpu_align_ctrl #(.MANTISSA_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .ma(ma), .mb(mb),
    .shift_spaces(shift_spaces), .exp_disc(exp_disc),
    .mantissa_a_out(mantissa_a_out), .mantissa_b_out(mantissa_b_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_ma(out_ma), .out_mb(out_mb),
    .out_exp(out_exp), .out_sa(out_sa), .out_sb(out_sb),
    .out_eff_sub(out_eff_sub), .out_special(out_special)
  );

  always #5 clk = ~clk;

  // External shifter: hidden one + mantissa + 3 guard bits, smaller operand
  // shifted right, one register stage.
  always @(posedge clk) begin
    mantissa_a_out <= (exp_disc == 2'b00) ? ({1'b1, ma, 3'b000} >> shift_spaces) : {1'b1, ma, 3'b000};
    mantissa_b_out <= (exp_disc == 2'b10) ? ({1'b1, mb, 3'b000} >> shift_spaces) : {1'b1, mb, 3'b000};
  end

  typedef struct {
    logic [26:0] ma_al, mb_al;
    logic [22:0] ma, mb;
    logic [7:0]  exp;
    logic        sa, sb, eff, spec;
    logic [1:0]  disc;
    logic [4:0]  sh;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 0;  // 0 high, 1 random, 2 low

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    exp_t e;
    int ea, eb, d;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    d  = (ea > eb) ? ea - eb : eb - ea;
    e.ma    = a[22:0];
    e.mb    = b[22:0];
    e.sa    = a[31];
    e.sb    = b[31];
    e.eff   = a[31] ^ b[31] ^ sub;
    e.spec  = (ea == 0) || (ea == 255) || (eb == 0) || (eb == 255);
    e.exp   = 8'((ea > eb) ? ea : eb);
    e.sh    = 5'((d > 31) ? 31 : d);
    e.disc  = (ea > eb) ? 2'b10 : (ea < eb) ? 2'b00 : 2'b11;
    e.ma_al = {1'b1, a[22:0], 3'b000};
    e.mb_al = {1'b1, b[22:0], 3'b000};
    if (ea < eb) e.ma_al = e.ma_al >> e.sh;
    if (ea > eb) e.mb_al = e.mb_al >> e.sh;
    return e;
  endfunction

  function automatic exp_t dir(input logic [26:0] ma_al, input logic [26:0] mb_al,
                               input logic [7:0] exp, input logic sa, input logic sb,
                               input logic eff, input logic spec, input logic [1:0] disc,
                               input logic [4:0] sh, input logic [22:0] ma_f, input logic [22:0] mb_f);
    exp_t e;
    e.ma_al = ma_al; e.mb_al = mb_al; e.exp = exp; e.sa = sa; e.sb = sb;
    e.eff = eff; e.spec = spec; e.disc = disc; e.sh = sh; e.ma = ma_f; e.mb = mb_f;
    return e;
  endfunction

  // Offer a pair; push the expectation only when the next edge accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic push, input exp_t e);
    int guard = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else if (push) q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((q.size() != 0 || !in_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_timeout", guard < 500, 1);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compares on every handshake, checks hold stability while stalled.
  logic         prev_v = 1'b0, prev_hs = 1'b0;
  logic [127:0] prev_bus = '0;
  always @(negedge clk) begin
    logic [127:0] bus;
    exp_t e;
    bus = {out_ma, out_mb, out_exp, out_sa, out_sb, out_eff_sub, out_special,
           exp_disc, shift_spaces, ma, mb};
    if (srst) begin
      prev_v = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_busy", in_ready, 0);
        if (prev_v && !prev_hs) chk("hold_stable", bus, prev_bus);
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_result", out_valid, 0);
          end else begin
            e = q.pop_front();
            chk("out_ma", out_ma, e.ma_al);
            chk("out_mb", out_mb, e.mb_al);
            chk("out_exp", out_exp, e.exp);
            chk("signs", {out_sa, out_sb}, {e.sa, e.sb});
            chk("eff_sub", out_eff_sub, e.eff);
            chk("special", out_special, e.spec);
            chk("exp_disc", exp_disc, e.disc);
            chk("shift", shift_spaces, e.sh);
            chk("ma_mb", {ma, mb}, {e.ma, e.mb});
          end
        end
      end
      prev_v   = out_valid;
      prev_hs  = out_valid && out_ready;
      prev_bus = bus;
    end
  end

  initial begin
    exp_t none;
    logic [31:0] a, b;
    int ea, eb;
    none = dir('0, '0, '0, 0, 0, 0, 0, 2'b11, '0, '0, '0);
    srst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exp_disc", exp_disc, 2'b11);
    chk("rst_zero", {ma, mb, shift_spaces, out_ma, out_mb, out_exp, out_sa, out_sb, out_eff_sub, out_special}, '0);

    // 3.0 + 1.0, with latency check
    send(32'h40400000, 32'h3F800000, 1'b0, 1'b1,
         dir(27'h6000000, 27'h2000000, 8'd128, 0, 0, 0, 0, 2'b10, 5'd1, 23'h400000, 23'h0));
    @(negedge clk); chk("lat_shift", out_valid, 0);
    @(negedge clk); chk("lat_capt", out_valid, 0);
    @(negedge clk); chk("lat_done", out_valid, 1);
    wait_idle();

    send(32'h3F800000, 32'h3F800000, 1'b0, 1'b1,
         dir(27'h4000000, 27'h4000000, 8'd127, 0, 0, 0, 0, 2'b11, 5'd0, 23'h0, 23'h0));
    wait_idle();
    send(32'h3F800000, 32'h4F800000, 1'b0, 1'b1,
         dir(27'h0, 27'h4000000, 8'd159, 0, 0, 0, 0, 2'b00, 5'd31, 23'h0, 23'h0));
    wait_idle();
    send(32'h7F800000, 32'hBF800000, 1'b0, 1'b1,
         dir(27'h4000000, 27'h0, 8'd255, 0, 1, 1, 1, 2'b10, 5'd31, 23'h0, 23'h0));
    wait_idle();

    // Backpressure: out_ready low while result is held
    ready_mode = 2;
    send(32'hC0A00000, 32'h40000000, 1'b1, 1'b1,
         model(32'hC0A00000, 32'h40000000, 1'b1));
    begin
      int guard = 0;
      while (!out_valid && guard < 10) begin @(negedge clk); guard++; end
      chk("stall_valid_seen", out_valid, 1);
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
    end
    ready_mode = 0;
    @(posedge clk); #2;
    @(negedge clk); chk("stall_last_valid", out_valid, 1);
    @(posedge clk); #2;
    chk("release_in_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
    wait_idle();

    // Reset while in SHIFT discards the operation
    send(32'h40400000, 32'h3F800000, 1'b0, 1'b0, none);
    srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_disc", exp_disc, 2'b11);
    repeat (10) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);

    // Randomized pairs with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      ea = int'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       eb = ea;
        1:       eb = ea + int'($urandom_range(0, 10)) - 5;
        2:       eb = int'($urandom_range(0, 255));
        default: eb = (ea >= 128) ? ea - 30 - int'($urandom_range(0, 3)) : ea + 30 + int'($urandom_range(0, 3));
      endcase
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      op_sub = 1'($urandom_range(0, 1));
      send(a, b, op_sub, 1'b1, model(a, b, op_sub));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ready_mode = 0;
    wait_idle();
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
